// File: rtl/bouncy_pkg.sv
// -----------------------------------------------------------------------------
// bouncy_pkg
// Shared definitions for the bouncing-point frame path: the scheduler FSM state
// type, frame geometry, the default SYNC byte and the frame checksum helper.
// Imported by the scheduler, the position generator and the testbench, so all
// three agree on what a frame looks like.
// -----------------------------------------------------------------------------
package bouncy_pkg;

    // Frame: SYNC, X, Y, CHK
    localparam int          FRAME_LEN         = 4;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0]  DROP_MAX          = 8'hFF;

    // Scheduler states, in the order they are visited for one frame.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP    = 3'd1,
        SNAP    = 3'd2,
        TX_SYNC = 3'd3,
        TX_X    = 3'd4,
        TX_Y    = 3'd5,
        TX_CHK  = 3'd6
    } state_t;

    // 8-bit XOR over the frame header and payload; x/y are raw bytes, the
    // sign is never interpreted and there are no carries.
    function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
        return sync ^ x ^ y;
    endfunction

endpackage

// File: rtl/bouncy_frame_sched_tick_div.sv
// -----------------------------------------------------------------------------
// bouncy_tick_div
// Step-rate divider. Counts 0..TICK_DIV-1 while enable is high and raises tick
// during the last count, then wraps. With enable low the counter is held at 0,
// so the next enable always starts a full period.
//
// Ports
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   enable  in  1  run the divider
//   tick    out 1  high for one cycle every TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module bouncy_tick_div #(
    parameter int TICK_DIV = 50000     // legal range >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Gated with enable so a falling enable can never leak a final tick.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/bouncy_frame_sched.sv
// -----------------------------------------------------------------------------
// bouncy_frame_sched
// Owns all step timing for the bouncing-point generator. On every divider tick
// (while idle) it pulses step_o once, snapshots the generator's new x/y, and
// streams the frame SYNC, X, Y, CHK to the UART transmitter over a valid/ready
// byte handshake. Ticks that arrive while a frame is in flight are counted in
// drop_cnt (saturating) instead of stepping the generator.
//
// Ports
//   clk       in  1  system clock, all logic on posedge
//   rst_n     in  1  asynchronous active-low reset; aborts any frame
//   enable    in  1  level; run the tick divider and start frames
//   step_o    out 1  one-cycle advance pulse to the position generator
//   x_i       in  8  generator x (two's complement), valid the cycle after step_o
//   y_i       in  8  generator y (two's complement), valid the cycle after step_o
//   tx_data   out 8  byte to UART TX, stable while tx_valid && !tx_ready
//   tx_valid  out 1  tx_data valid, registered, held until accepted
//   tx_ready  in  1  UART TX accepts on tx_valid && tx_ready
//   busy      out 1  high in every state except IDLE
//   drop_cnt  out 8  ticks lost to an in-flight frame, saturates at 255
// -----------------------------------------------------------------------------
module bouncy_frame_sched
    import bouncy_pkg::*;
#(
    parameter int         TICK_DIV  = 50000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       step_o,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    state_t     state;
    logic       tick;
    logic       accept;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [7:0] chk_q;

    bouncy_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // tx_ready only decides whether the FSM moves on; it never reaches
    // tx_valid combinationally, so the UART side sees a clean registered valid.
    assign accept = tx_valid && tx_ready;

    // -------------------------------------------------------------------------
    // Frame FSM with registered outputs. Each transition loads the outputs that
    // belong to the state being entered, so step_o/tx_valid/tx_data/busy line
    // up exactly with the state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_o   <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            x_q      <= 8'h00;
            y_q      <= 8'h00;
            chk_q    <= 8'h00;
        end else begin
            step_o <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick on the cycle we return to IDLE is taken here, so
                    // back-to-back frames need no dead cycle.
                    if (tick) begin
                        state  <= STEP;
                        step_o <= 1'b1;
                        busy   <= 1'b1;
                    end
                end

                STEP: begin
                    // The generator advances on this edge; its outputs settle
                    // for the SNAP cycle.
                    state <= SNAP;
                end

                SNAP: begin
                    x_q      <= x_i;
                    y_q      <= y_i;
                    chk_q    <= frame_chk(SYNC_BYTE, x_i, y_i);
                    state    <= TX_SYNC;
                    tx_valid <= 1'b1;
                    tx_data  <= SYNC_BYTE;
                end

                TX_SYNC: begin
                    if (accept) begin
                        state   <= TX_X;
                        tx_data <= x_q;
                    end
                end

                TX_X: begin
                    if (accept) begin
                        state   <= TX_Y;
                        tx_data <= y_q;
                    end
                end

                TX_Y: begin
                    if (accept) begin
                        state   <= TX_CHK;
                        tx_data <= chk_q;
                    end
                end

                TX_CHK: begin
                    if (accept) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Overrun counter: any tick that finds the FSM outside IDLE is lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (tick && (state != IDLE) && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
